// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues imem req/ack fetches and presents
// each fetched word to decode over valid/ready, with stall, redirect and enable handling.
module fetch_controller #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       fetch_count
);

  // Encoding keeps imem_req and instr_valid as direct flop bits.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StHold = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [31:0]       count_q, count_d;
  logic              squash_q, squash_d;
  logic              transfer;

  assign transfer = (state_q == StHold) && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      count_q    <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      squash_q   <= squash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (fetch_en) state_d = StReq;
      StReq:  if (imem_ack && !squash_q && !redirect_valid) state_d = StHold;
      StHold: if (redirect_valid || instr_ready) state_d = fetch_en ? StReq : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    target_d   = target_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    squash_d   = squash_q;
    case (state_q)
      StIdle: if (redirect_valid) pc_d = redirect_pc;
      StReq: begin
        if (imem_ack) begin
          squash_d = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (squash_q) begin
            pc_d = target_q;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
          end
        end else if (redirect_valid) begin
          // Address must stay stable until the ack; remember where to go afterwards.
          target_d = redirect_pc;
          squash_d = 1'b1;
        end
      end
      StHold: begin
        if (transfer) count_d = count_q + 32'd1;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (transfer) begin
          pc_d = pc_q + ADDR_W'(PC_STEP);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == StReq);
    instr_valid = (state_q == StHold);
    imem_addr   = pc_q;
    pc          = pc_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
    fetch_count = count_q;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic
// checked against a program-order reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect_valid, imem_req, imem_ack, instr_valid, instr_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc, pc, fetch_count;

  logic        w_reset, w_fetch_en, w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_instr_pc, w_pc, w_count;

  int unsigned lat, mcnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .pc(pc),
    .fetch_count(fetch_count)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(w_reset), .fetch_en(w_fetch_en), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_rdata), .instr_valid(w_valid),
    .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc), .pc(w_pc),
    .fetch_count(w_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory: acks once a request has waited `lat` cycles (lat=0 acks the same cycle).
  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (!imem_req || imem_ack) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end
  assign imem_ack   = imem_req && (mcnt >= lat);
  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a, input string tag);
    logic found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  logic [31:0] exp_pc, prev_addr;
  int unsigned cnt_m;
  logic        prev_req, prev_ack, seen;

  initial begin
    reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; lat = 0;
    w_reset = 1'b1; w_fetch_en = 1'b0;

    // 1: reset values, then back-to-back fetch with same-cycle ack
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_valid", 32'(instr_valid), 32'(i % 2));
      if (i % 2 == 1) begin
        check("t1_instr_pc", instr_pc, 32'(4 * (i / 2)));
        check("t1_instr", instr, mem_word(32'(4 * (i / 2))));
      end
    end
    @(negedge clk);
    check("t1_count", fetch_count, 32'd4);
    check("t1_next_addr", imem_addr, 32'd16);

    // 2: stall while holding the word at 8
    do_reset();
    wait_addr(32'h8, "t2_reach");
    instr_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t2_valid", 32'(instr_valid), 32'd1);
      check("t2_instr_pc", instr_pc, 32'h8);
      check("t2_instr", instr, mem_word(32'h8));
      check("t2_pc", pc, 32'h8);
      check("t2_count", fetch_count, 32'd2);
      check("t2_no_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    check("t2_req", 32'(imem_req), 32'd1);
    check("t2_addr", imem_addr, 32'hC);
    check("t2_count_after", fetch_count, 32'd3);

    // 3: redirect while a stalled word is held
    do_reset();
    wait_addr(32'h4, "t3_reach");
    instr_ready = 1'b0;
    @(negedge clk);
    check("t3_held_pc", instr_pc, 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t3_valid", 32'(instr_valid), 32'd0);
    check("t3_req", 32'(imem_req), 32'd1);
    check("t3_addr", imem_addr, 32'h40);
    check("t3_count", fetch_count, 32'd1);
    instr_ready = 1'b1;

    // 4: redirect during a 3-cycle-latency request
    lat = 2;
    do_reset();
    wait_addr(32'h10, "t4_reach");
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t4_addr_stable", imem_addr, 32'h10);
    check("t4_req_stable", 32'(imem_req), 32'd1);
    @(negedge clk);
    check("t4_new_addr", imem_addr, 32'h80);
    check("t4_no_valid", 32'(instr_valid), 32'd0);
    check("t4_count", fetch_count, 32'd4);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        check("t4_instr_pc", instr_pc, 32'h80);
        check("t4_instr", instr, mem_word(32'h80));
      end
    end
    check("t4_seen", 32'(seen), 32'd1);

    // 5: asynchronous reset with a request outstanding
    do_reset();
    wait_addr(32'h20, "t5_reach");
    reset = 1'b1;
    #1;
    check("t5_req", 32'(imem_req), 32'd0);
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_pc", pc, 32'h0);
    check("t5_instr", instr, 32'h0);
    check("t5_instr_pc", instr_pc, 32'h0);
    check("t5_count", fetch_count, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_restart_req", 32'(imem_req), 32'd1);
    check("t5_restart_addr", imem_addr, 32'h0);

    // 6: PC wrap and fetch_en dropped while holding
    @(negedge clk);
    w_reset = 1'b0; w_fetch_en = 1'b1;
    @(negedge clk);
    check("t6_req", 32'(w_req), 32'd1);
    check("t6_addr", w_addr, 32'hFFFF_FFFC);
    w_fetch_en = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(w_valid), 32'd1);
    check("t6_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    check("t6_instr", w_instr, mem_word(32'hFFFF_FFFC));
    @(negedge clk);
    check("t6_pc_wrap", w_pc, 32'h0);
    check("t6_idle_req", 32'(w_req), 32'd0);
    check("t6_idle_valid", 32'(w_valid), 32'd0);
    check("t6_count", w_count, 32'd1);
    @(negedge clk);
    check("t6_still_idle", 32'(w_req), 32'd0);

    // Randomized traffic against a program-order model
    lat = 0;
    do_reset();
    exp_pc = 32'h0; cnt_m = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rnd_count", fetch_count, cnt_m);
      check("rnd_excl", 32'(imem_req & instr_valid), 32'd0);
      if (prev_req && !prev_ack) begin
        check("rnd_req_held", 32'(imem_req), 32'd1);
        check("rnd_addr_stable", imem_addr, prev_addr);
      end
      fetch_en       = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 8) == 0;
      redirect_pc    = 32'($urandom_range(0, 255)) << 2;
      if (!imem_req) lat = $urandom_range(0, 3);
      #1;
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      if (instr_valid && instr_ready) begin
        check("rnd_instr_pc", instr_pc, exp_pc);
        check("rnd_instr", instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        cnt_m++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    @(negedge clk);
    check("rnd_final_count", fetch_count, cnt_m);
    check("rnd_progress", 32'(cnt_m > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
